// File: rtl/axi_dac_jesd204_src_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_dac_jesd204_src_mux
// Brief    : Per-channel DAC sample source (DMA / zero / ramp / PN7 / PN15)
//            feeding the JESD204 TX lane framer, with sticky DMA underflow.
// Revision : 1.0 - initial release
// ============================================================================
module axi_dac_jesd204_src_mux #(
    parameter int NUM_LANES    = 8,
    parameter int NUM_CHANNELS = 4
) (
    input  logic                      dac_clk,
    input  logic                      dac_rst,
    input  logic [NUM_CHANNELS*4-1:0] dac_data_sel,
    input  logic                      dac_sync,
    input  logic [NUM_LANES*32-1:0]   dma_data,
    input  logic                      dma_valid,
    output logic                      dma_ready,
    output logic [NUM_LANES*32-1:0]   dac_data,
    output logic                      dac_dunf,
    input  logic                      dac_dunf_clr
);

    localparam int C_DPW     = 2 * NUM_LANES / NUM_CHANNELS;
    localparam int C_CH_W    = C_DPW * 16;
    localparam int C_DATA_W  = NUM_LANES * 32;

    localparam logic [3:0]  C_SEL_DMA  = 4'd0;
    localparam logic [3:0]  C_SEL_RAMP = 4'd2;
    localparam logic [3:0]  C_SEL_PN7  = 4'd3;
    localparam logic [3:0]  C_SEL_PN15 = 4'd4;

    localparam logic [6:0]  C_PN7_SEED  = 7'h7F;
    localparam logic [14:0] C_PN15_SEED = 15'h7FFF;

    logic [15:0]           ramp_q, ramp_d;
    logic [6:0]            pn7_q, pn7_d, pn7_adv;
    logic [14:0]           pn15_q, pn15_d, pn15_adv;
    logic [C_DATA_W-1:0]   data_q, data_d;
    logic                  ready_q;
    logic                  dunf_q;

    logic [C_CH_W-1:0]     ramp_word;
    logic [C_CH_W-1:0]     pn7_word;
    logic [C_CH_W-1:0]     pn15_word;
    logic [NUM_CHANNELS-1:0] dma_sel;
    logic                  underflow;

    always_comb begin
        ramp_word = '0;
        for (int j = 0; j < C_DPW; j++) begin
            ramp_word[j*16 +: 16] = ramp_q + 16'(j);
        end
    end

    // Fully unrolled LFSRs: the first generated bit lands in the MSB of sample 0.
    always_comb begin
        logic [6:0] s;
        logic       b;
        s        = pn7_q;
        b        = 1'b0;
        pn7_word = '0;
        for (int j = 0; j < C_DPW; j++) begin
            for (int k = 15; k >= 0; k--) begin
                b                  = s[6] ^ s[5];
                pn7_word[j*16 + k] = b;
                s                  = {s[5:0], b};
            end
        end
        pn7_adv = s;
    end

    always_comb begin
        logic [14:0] s;
        logic        b;
        s         = pn15_q;
        b         = 1'b0;
        pn15_word = '0;
        for (int j = 0; j < C_DPW; j++) begin
            for (int k = 15; k >= 0; k--) begin
                b                   = s[14] ^ s[13];
                pn15_word[j*16 + k] = b;
                s                   = {s[13:0], b};
            end
        end
        pn15_adv = s;
    end

    always_comb begin
        if (dac_sync) begin
            ramp_d = '0;
            pn7_d  = C_PN7_SEED;
            pn15_d = C_PN15_SEED;
        end else begin
            ramp_d = ramp_q + 16'(C_DPW);
            pn7_d  = pn7_adv;
            pn15_d = pn15_adv;
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
        logic [3:0]        sel;
        logic [C_CH_W-1:0] word;

        assign sel        = dac_data_sel[4*i +: 4];
        assign dma_sel[i] = (sel == C_SEL_DMA);

        always_comb begin
            case (sel)
                C_SEL_DMA:  word = dma_valid ? dma_data[i*C_CH_W +: C_CH_W] : '0;
                C_SEL_RAMP: word = ramp_word;
                C_SEL_PN7:  word = pn7_word;
                C_SEL_PN15: word = pn15_word;
                default:    word = '0;
            endcase
        end

        assign data_d[i*C_CH_W +: C_CH_W] = word;
    end

    assign underflow = (|dma_sel) & ~dma_valid;

    always_ff @(posedge dac_clk or posedge dac_rst) begin
        if (dac_rst) begin
            data_q  <= '0;
            ramp_q  <= '0;
            pn7_q   <= C_PN7_SEED;
            pn15_q  <= C_PN15_SEED;
            ready_q <= 1'b0;
            dunf_q  <= 1'b0;
        end else begin
            data_q  <= data_d;
            ramp_q  <= ramp_d;
            pn7_q   <= pn7_d;
            pn15_q  <= pn15_d;
            ready_q <= |dma_sel;
            // A new underflow outranks a simultaneous clear.
            if (underflow) begin
                dunf_q <= 1'b1;
            end else if (dac_dunf_clr) begin
                dunf_q <= 1'b0;
            end
        end
    end

    assign dac_data  = data_q;
    assign dma_ready = ready_q;
    assign dac_dunf  = dunf_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_dac_jesd204_src_mux.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_dac_jesd204_src_mux
// Brief    : Self-checking bench with a serial-LFSR / integer-ramp reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_dac_jesd204_src_mux;

    localparam int NL  = 8;
    localparam int NC  = 4;
    localparam int DPW = 2 * NL / NC;
    localparam int DW  = NL * 32;

    logic           dac_clk;
    logic           dac_rst;
    logic [NC*4-1:0] dac_data_sel;
    logic           dac_sync;
    logic [DW-1:0]  dma_data;
    logic           dma_valid;
    logic           dma_ready;
    logic [DW-1:0]  dac_data;
    logic           dac_dunf;
    logic           dac_dunf_clr;

    axi_dac_jesd204_src_mux #(
        .NUM_LANES    (NL),
        .NUM_CHANNELS (NC)
    ) dut (
        .dac_clk      (dac_clk),
        .dac_rst      (dac_rst),
        .dac_data_sel (dac_data_sel),
        .dac_sync     (dac_sync),
        .dma_data     (dma_data),
        .dma_valid    (dma_valid),
        .dma_ready    (dma_ready),
        .dac_data     (dac_data),
        .dac_dunf     (dac_dunf),
        .dac_dunf_clr (dac_dunf_clr)
    );

    initial dac_clk = 1'b0;
    always #5 dac_clk = ~dac_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: ramp as a plain integer, PN generators as serial LFSRs.
    int          m_r;
    logic [6:0]  m_s7;
    logic [14:0] m_s15;
    logic [DW-1:0] exp_data;
    logic        exp_dunf;
    logic        exp_ready;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_r       = 0;
        m_s7      = 7'h7F;
        m_s15     = 15'h7FFF;
        exp_data  = '0;
        exp_dunf  = 1'b0;
        exp_ready = 1'b0;
    endtask

    task automatic model_cycle();
        logic [15:0] rs  [DPW];
        logic [15:0] p7  [DPW];
        logic [15:0] p15 [DPW];
        logic [3:0]  sel;
        logic        b;
        bit          any_dma;
        int          idx;
        for (int j = 0; j < DPW; j++) rs[j] = 16'((m_r + j) % 65536);
        for (int j = 0; j < DPW; j++) begin
            for (int k = 15; k >= 0; k--) begin
                b = m_s7[6] ^ m_s7[5];
                m_s7 = {m_s7[5:0], b};
                p7[j][k] = b;
                b = m_s15[14] ^ m_s15[13];
                m_s15 = {m_s15[13:0], b};
                p15[j][k] = b;
            end
        end
        any_dma = 0;
        for (int ch = 0; ch < NC; ch++) begin
            sel = dac_data_sel[4*ch +: 4];
            if (sel == 4'd0) any_dma = 1;
            for (int j = 0; j < DPW; j++) begin
                idx = (ch * DPW + j) * 16;
                case (sel)
                    4'd0:    exp_data[idx +: 16] = dma_valid ? dma_data[idx +: 16] : 16'h0;
                    4'd2:    exp_data[idx +: 16] = rs[j];
                    4'd3:    exp_data[idx +: 16] = p7[j];
                    4'd4:    exp_data[idx +: 16] = p15[j];
                    default: exp_data[idx +: 16] = 16'h0;
                endcase
            end
        end
        exp_ready = any_dma;
        if (any_dma && !dma_valid) exp_dunf = 1'b1;
        else if (dac_dunf_clr)     exp_dunf = 1'b0;
        if (dac_sync) begin
            m_r   = 0;
            m_s7  = 7'h7F;
            m_s15 = 15'h7FFF;
        end else begin
            m_r = (m_r + DPW) % 65536;
        end
    endtask

    task automatic step();
        model_cycle();
        @(posedge dac_clk);
        #1;
        check("dac_data", dac_data, exp_data);
        check("dac_dunf", {255'b0, dac_dunf}, {255'b0, exp_dunf});
        check("dma_ready", {255'b0, dma_ready}, {255'b0, exp_ready});
    endtask

    task automatic do_reset();
        dac_rst = 1'b1;
        repeat (2) @(posedge dac_clk);
        #1;
        check("rst_data", dac_data, '0);
        check("rst_dunf", {255'b0, dac_dunf}, '0);
        check("rst_ready", {255'b0, dma_ready}, '0);
        dac_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [DW-1:0] prev_dma;
        logic [15:0]   base;
        dac_rst      = 1'b1;
        dac_data_sel = 16'h1111;
        dac_sync     = 1'b0;
        dma_data     = '0;
        dma_valid    = 1'b0;
        dac_dunf_clr = 1'b0;
        model_reset();

        // All channels zero-source after reset release.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            check("sel1_zero", dac_data, '0);
        end

        // Ramp on channel 0, including a full 16-bit wrap.
        do_reset();
        dac_data_sel = 16'h1112;
        step();
        check("ramp_w0", {192'b0, dac_data[63:0]}, {192'b0, 64'h0003_0002_0001_0000});
        step();
        check("ramp_w1", {192'b0, dac_data[63:0]}, {192'b0, 64'h0007_0006_0005_0004});
        for (int k = 2; k <= 16384; k++) begin
            step();
            if (k == 16383)
                check("ramp_wrap_hi", {192'b0, dac_data[63:0]}, {192'b0, 64'hFFFF_FFFE_FFFD_FFFC});
            if (k == 16384)
                check("ramp_wrap_lo", {192'b0, dac_data[63:0]}, {192'b0, 64'h0003_0002_0001_0000});
        end

        // PN7 on channel 1, then realign with dac_sync.
        do_reset();
        dac_data_sel = 16'h1131;
        step();
        check("pn7_first", {240'b0, dac_data[64 +: 16]}, {240'b0, 16'h020C});
        for (int i = 0; i < 999; i++) step();
        dac_sync = 1'b1;
        step();
        dac_sync = 1'b0;
        step();
        check("pn7_resync", {240'b0, dac_data[64 +: 16]}, {240'b0, 16'h020C});

        // DMA pass-through on all channels.
        dac_data_sel = 16'h0000;
        dma_valid    = 1'b1;
        base         = 16'h1000;
        for (int i = 0; i < 40; i++) begin
            for (int s = 0; s < 16; s++) dma_data[s*16 +: 16] = base + 16'(s);
            base     = base + 16'd16;
            prev_dma = dma_data;
            step();
            check("dma_pass", dac_data, prev_dma);
            if (i >= 1) check("dma_ready_hi", {255'b0, dma_ready}, {255'b0, 1'b1});
        end

        // Underflow on channel 2 while the others ramp.
        dac_data_sel = 16'h2022;
        for (int i = 0; i < 3; i++) step();
        dma_valid = 1'b0;
        step();
        check("unf_ch2_zero", {192'b0, dac_data[128 +: 64]}, '0);
        check("unf_flag", {255'b0, dac_dunf}, {255'b0, 1'b1});
        dma_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("unf_sticky", {255'b0, dac_dunf}, {255'b0, 1'b1});
        end
        dma_valid    = 1'b0;
        dac_dunf_clr = 1'b1;
        step();
        check("unf_set_wins", {255'b0, dac_dunf}, {255'b0, 1'b1});
        dma_valid    = 1'b1;
        step();
        check("unf_clr_cleared", {255'b0, dac_dunf}, '0);
        dac_dunf_clr = 1'b0;
        step();

        // Asynchronous reset in the middle of a PN15 stream.
        do_reset();
        dac_data_sel = 16'h4444;
        for (int i = 0; i < 20; i++) step();
        #3;
        dac_rst = 1'b1;
        #1;
        check("async_rst_data", dac_data, '0);
        check("async_rst_dunf", {255'b0, dac_dunf}, '0);
        @(posedge dac_clk);
        #1;
        dac_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) step();

        // Randomized mix of selects, validity, sync and clear.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                for (int ch = 0; ch < NC; ch++) dac_data_sel[4*ch +: 4] = 4'($urandom_range(0, 6));
            end
            for (int w = 0; w < DW / 32; w++) dma_data[w*32 +: 32] = $urandom;
            dma_valid    = ($urandom_range(0, 7) != 0);
            dac_sync     = ($urandom_range(0, 31) == 0);
            dac_dunf_clr = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
